// File: rtl/csa_spec_err_recover.sv
// Carry-speculative adder: block carries are guessed from the MSB pair of the lower block.
// A wrong guess is flagged and repaired with the exact sum after a fixed recovery delay.
module csa_spec_err_recover #(
  parameter int WIDTH     = 16,
  parameter int BLK       = 4,
  parameter int RECOV_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum,
  output logic                     cout,
  output logic                     err_flag,
  output logic [WIDTH/BLK-2:0]     err_blk,
  output logic [CNT_W-1:0]         err_cnt,
  input  logic                     err_cnt_clr
);

  localparam int NB = WIDTH / BLK;
  localparam int RW = (RECOV_CYC > 1) ? $clog2(RECOV_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SPEC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  opA_q, opA_d, opB_q, opB_d;
  logic              cin_q, cin_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              errFlag_q, errFlag_d;
  logic [NB-2:0]     errBlk_q, errBlk_d;
  logic [CNT_W-1:0]  errCnt_q, errCnt_d;
  logic [RW-1:0]     recCnt_q, recCnt_d;

  logic [WIDTH:0]    exactSum;
  logic [WIDTH-1:0]  specSum;
  logic              specCout;
  logic [NB-1:0]     cSpec;
  logic [NB-1:0]     cTrue;
  logic [NB-2:0]     errVec;
  logic [BLK:0]      blkSum;

  // Speculative per-block sums next to the exact reference; the true carry into a
  // block boundary is recovered from the exact sum bit and the operand bits there.
  always_comb begin
    exactSum = {1'b0, opA_q} + {1'b0, opB_q} + {{WIDTH{1'b0}}, cin_q};
    specSum  = '0;
    specCout = 1'b0;
    cSpec    = '0;
    cTrue    = '0;
    errVec   = '0;
    blkSum   = '0;
    for (int k = 0; k < NB; k++) begin
      if (k == 0) begin
        cSpec[k] = cin_q;
        cTrue[k] = cin_q;
      end else begin
        cSpec[k]    = opA_q[k*BLK-1] & opB_q[k*BLK-1];
        cTrue[k]    = exactSum[k*BLK] ^ opA_q[k*BLK] ^ opB_q[k*BLK];
        errVec[k-1] = cSpec[k] ^ cTrue[k];
      end
      blkSum = {1'b0, opA_q[k*BLK +: BLK]} + {1'b0, opB_q[k*BLK +: BLK]}
             + {{BLK{1'b0}}, cSpec[k]};
      specSum[k*BLK +: BLK] = blkSum[BLK-1:0];
      specCout = blkSum[BLK];
    end
  end

  // Control FSM and result/statistics next-state
  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    cin_d     = cin_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    errFlag_d = errFlag_q;
    errBlk_d  = errBlk_q;
    errCnt_d  = errCnt_q;
    recCnt_d  = recCnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opA_d   = a;
          opB_d   = b;
          cin_d   = cin;
          state_d = SPEC;
        end
      end
      SPEC: begin
        if (|errVec) begin
          errBlk_d  = errVec;
          errFlag_d = 1'b1;
          recCnt_d  = RW'(RECOV_CYC - 1);
          if (!(&errCnt_q)) errCnt_d = errCnt_q + 1'b1;
          state_d   = FIX;
        end else begin
          sum_d     = specSum;
          cout_d    = specCout;
          errFlag_d = 1'b0;
          errBlk_d  = '0;
          state_d   = DONE;
        end
      end
      FIX: begin
        if (recCnt_q == '0) begin
          sum_d   = exactSum[WIDTH-1:0];
          cout_d  = exactSum[WIDTH];
          state_d = DONE;
        end else begin
          recCnt_d = recCnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clearing the statistics must beat an increment landing on the same edge
    if (err_cnt_clr) errCnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      cin_q     <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      errFlag_q <= 1'b0;
      errBlk_q  <= '0;
      errCnt_q  <= '0;
      recCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      cin_q     <= cin_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      errFlag_q <= errFlag_d;
      errBlk_q  <= errBlk_d;
      errCnt_q  <= errCnt_d;
      recCnt_q  <= recCnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err_flag  = errFlag_q;
  assign err_blk   = errBlk_q;
  assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_csa_spec_err_recover.sv
// Directed bench for csa_spec_err_recover; a second instance with a 2-bit counter
// shares all inputs to exercise counter saturation.
module tb_csa_spec_err_recover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cin, err_cnt_clr;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cout, err_flag;
  logic [15:0] sum;
  logic [2:0]  err_blk;
  logic [7:0]  err_cnt;
  logic        in_ready2, out_valid2, cout2, err_flag2;
  logic [15:0] sum2;
  logic [2:0]  err_blk2;
  logic [1:0]  err_cnt2;

  int testsRun = 0;
  int testsFailed = 0;
  int expCnt = 0;
  int expCnt2 = 0;

  always #5 clk = ~clk;

  csa_spec_err_recover #(.WIDTH(16), .BLK(4), .RECOV_CYC(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err_flag(err_flag), .err_blk(err_blk),
    .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
  );

  csa_spec_err_recover #(.WIDTH(16), .BLK(4), .RECOV_CYC(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid2), .out_ready(out_ready),
    .sum(sum2), .cout(cout2), .err_flag(err_flag2), .err_blk(err_blk2),
    .err_cnt(err_cnt2), .err_cnt_clr(err_cnt_clr)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] s;
    logic        co;
    logic        f;
    logic [2:0]  blk;
    int          lat;
  } vec_t;

  // Drive one operand set and wait for out_valid; lat counts rising edges from the
  // accept edge (inclusive) to the edge that raises out_valid.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic c, output int lat);
    @(negedge clk);
    a = av; b = bv; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic releaseOutput();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic bumpCounts();
    if (expCnt < 255) expCnt++;
    if (expCnt2 < 3) expCnt2++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0;
    err_cnt_clr = 1'b0; a = '0; b = '0;
    #12;
    testsRun++;
    if ({out_valid, sum, cout, err_flag, err_blk, err_cnt} !== 29'd0 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: ov=%b sum=%h cout=%b flag=%b blk=%b cnt=%0d rdy=%b, want all 0 and rdy=1",
               out_valid, sum, cout, err_flag, err_blk, err_cnt, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    vec_t vecs[9];
    int lat;
    vecs[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 3'b000, 2};
    vecs[1] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b1, 3'b001, 4};
    vecs[2] = '{16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0, 1'b0, 3'b000, 2};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 3'b111, 4};
    vecs[4] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b1, 3'b011, 4};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 3'b000, 2};
    vecs[6] = '{16'h0880, 16'h0880, 1'b0, 16'h1100, 1'b0, 1'b0, 3'b000, 2};
    vecs[7] = '{16'h0F00, 16'h0100, 1'b0, 16'h1000, 1'b0, 1'b1, 3'b100, 4};
    vecs[8] = '{16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 3'b000, 2};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, lat);
      if (vecs[i].f) bumpCounts();
      testsRun++;
      if (lat !== vecs[i].lat) begin
        testsFailed++;
        $display("[TB] FAIL vec%0d_latency: got %0d, want %0d", i, lat, vecs[i].lat);
      end
      testsRun++;
      if (sum !== vecs[i].s || cout !== vecs[i].co || sum2 !== vecs[i].s) begin
        testsFailed++;
        $display("[TB] FAIL vec%0d_sum: got %h/%b (inst2 %h), want %h/%b",
                 i, sum, cout, sum2, vecs[i].s, vecs[i].co);
      end
      testsRun++;
      if (err_flag !== vecs[i].f || err_blk !== vecs[i].blk) begin
        testsFailed++;
        $display("[TB] FAIL vec%0d_err: got flag=%b blk=%b, want flag=%b blk=%b",
                 i, err_flag, err_blk, vecs[i].f, vecs[i].blk);
      end
      testsRun++;
      if (err_cnt !== 8'(expCnt)) begin
        testsFailed++;
        $display("[TB] FAIL vec%0d_cnt: got %0d, want %0d", i, err_cnt, expCnt);
      end
      releaseOutput();
    end
  endtask

  task automatic test_hold();
    int lat;
    applyStimulus(16'h000F, 16'h0001, 1'b0, lat);
    bumpCounts();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
      @(posedge clk); #1;
      testsRun++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0010 ||
          err_flag !== 1'b1 || err_blk !== 3'b001 || err_cnt !== 8'(expCnt)) begin
        testsFailed++;
        $display("[TB] FAIL hold_cycle%0d: ov=%b rdy=%b sum=%h flag=%b blk=%b cnt=%0d, want 1 0 0010 1 001 %0d",
                 i, out_valid, in_ready, sum, err_flag, err_blk, err_cnt, expCnt);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    testsRun++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hold_release: ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk); #1;
    testsRun++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hold_ignored_input: ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] seen;
    logic [8:0] want;
    int badSum;
    want = 9'b010_010_010;
    seen = '0;
    badSum = 0;
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      seen[8-i] = out_valid;
      if (out_valid && sum !== 16'h0003) badSum++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    testsRun++;
    if (seen !== want || badSum != 0) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back: ov pattern %b, want %b, bad sums %0d",
               seen, want, badSum);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 16'h000F; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    expCnt = 0;
    expCnt2 = 0;
    testsRun++;
    if ({out_valid, sum, cout, err_flag, err_blk, err_cnt} !== 29'd0 || err_cnt2 !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_fix: ov=%b sum=%h cout=%b flag=%b blk=%b cnt=%0d cnt2=%0d, want all 0",
               out_valid, sum, cout, err_flag, err_blk, err_cnt, err_cnt2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    testsRun++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_after: rdy=%b ov=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_cnt_sat();
    int lat;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h000F, 16'h0001, 1'b0, lat);
      bumpCounts();
      testsRun++;
      if (err_cnt2 !== 2'(expCnt2) || err_cnt !== 8'(expCnt)) begin
        testsFailed++;
        $display("[TB] FAIL cnt_sat_op%0d: cnt2=%0d cnt=%0d, want %0d %0d",
                 i, err_cnt2, err_cnt, expCnt2, expCnt);
      end
      releaseOutput();
    end
    testsRun++;
    if (err_cnt2 !== 2'd3) begin
      testsFailed++;
      $display("[TB] FAIL cnt_saturated: got %0d, want 3", err_cnt2);
    end
  endtask

  task automatic test_cnt_clr();
    int lat;
    @(negedge clk);
    err_cnt_clr = 1'b1;
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, lat);
    @(negedge clk);
    err_cnt_clr = 1'b0;
    expCnt = 0;
    expCnt2 = 0;
    testsRun++;
    if (err_cnt !== 8'd0 || err_cnt2 !== 2'd0 || err_flag !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL cnt_clr_wins: cnt=%0d cnt2=%0d flag=%b, want 0 0 1",
               err_cnt, err_cnt2, err_flag);
    end
    releaseOutput();
    applyStimulus(16'h000F, 16'h0001, 1'b0, lat);
    bumpCounts();
    testsRun++;
    if (err_cnt !== 8'(expCnt) || err_cnt2 !== 2'(expCnt2)) begin
      testsFailed++;
      $display("[TB] FAIL cnt_after_clr: cnt=%0d cnt2=%0d, want %0d %0d",
               err_cnt, err_cnt2, expCnt, expCnt2);
    end
    releaseOutput();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_cnt_sat();
    test_cnt_clr();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/csa_spec_err_recover.md
Name: csa_spec_err_recover

Overview:
- Parametrised carry-speculative adder with block-level error detection and multi-cycle recovery.
- Splits WIDTH-bit operands into BLK-bit blocks. Each block's carry-in is speculated from the generate of the lower block's MSB pair.
- Per-block speculation errors are detected and OR-reduced into one flag. On error, a recovery FSM substitutes the exact sum after RECOV_CYC cycles.
- Sits between the operand source and the result consumer on valid/ready handshakes. Keeps a saturating error counter for accuracy statistics.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of BLK.
- BLK, 4, speculation block size in bits; WIDTH/BLK (NB) must be >= 2.
- RECOV_CYC, 2, cycles spent in recovery state (>= 1).
- CNT_W, 8, width of error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to block 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result (speculative if no error, exact if corrected).
- cout  out  1  carry-out of MSB.
- err_flag  out  1  speculation error detected for this result.
- err_blk  out  NB-1  per-block error mask; bit k-1 is block k, k = 1..NB-1.
- err_cnt  out  CNT_W  saturating count of erroneous operations.
- err_cnt_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1.
  - out_valid, sum, cout, err_flag, err_blk and err_cnt all 0.
  - Operand registers cleared.
  - Reset mid-operation aborts the operation with no output.
- States: IDLE, SPEC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register a, b, cin and go to SPEC.
- SPEC (registered operands):
  - c_spec[0] = cin.
  - c_spec[k] = a[k*BLK-1] & b[k*BLK-1], for k >= 1.
  - Block k sum = a_blk + b_blk + c_spec[k].
  - c_true[k] = true carry into bit k*BLK of a+b+cin.
  - err[k] = c_spec[k] XOR c_true[k].
  - Speculation can only under-predict: c_spec=1 implies c_true=1.
  - err_flag = OR of err[1..NB-1].
  - No error: latch spec sum and spec cout (equal to exact), err_flag=0, err_blk=0, then go to DONE.
  - Error: latch err_blk and err_flag=1, increment err_cnt, load recovery counter, then go to FIX.
- FIX:
  - Stays exactly RECOV_CYC cycles.
  - On the last cycle, latch the exact sum/cout (a+b+cin, WIDTH+1 bits), then go to DONE.
- DONE:
  - out_valid=1. sum, cout, err_flag and err_blk are held stable while out_ready=0.
  - On out_ready: out_valid falls next cycle, state goes to IDLE.
  - in_ready=0 in every state except IDLE.
- Latency, counted from the accept edge:
  - No error: out_valid is asserted 2 cycles after accept.
  - Error: out_valid is asserted 2+RECOV_CYC cycles after accept.
  - Minimum initiation interval is 3 cycles.
- err_cnt:
  - Increments on the SPEC->FIX transition.
  - Saturates at all-ones.
  - err_cnt_clr forces it to 0 and wins over a simultaneous increment.
  - Unaffected by out_ready.
- Outputs are registered; no combinational path from in_* to out_*.

Test Plan (WIDTH=16, BLK=4, RECOV_CYC=2 unless noted):
- a=0x0001, b=0x0002, cin=0 -> sum=0x0003, cout=0, err_flag=0, err_blk=3'b000, out_valid 2 cycles after accept, err_cnt unchanged.
- a=0x000F, b=0x0001 -> err_blk=3'b001, err_flag=1, sum=0x0010, out_valid 4 cycles after accept, err_cnt=1.
- a=0x0008, b=0x0008 (c_spec[1]=1, correct) -> sum=0x0010, err_flag=0, latency 2.
- a=0xFFFF, b=0x0001 -> err_blk=3'b111, sum=0x0000, cout=1, latency 4.
- Hold out_ready=0 for 5 cycles in DONE -> sum/flags stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
- Reset and counter:
  - Assert rst_n=0 during FIX -> all outputs 0 immediately; in_ready=1 after release.
  - With CNT_W=2, run 4 erroring ops -> err_cnt=3.
  - err_cnt_clr together with an erroring SPEC -> err_cnt=0.
